// File: rtl/uart_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_pkg
// Description : Shared types and constants for the UART receive path and the
//               matching transmitter.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_pkg;

  // Receiver FSM state encoding
  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_START  = 3'd1,
    ST_DATA   = 3'd2,
    ST_PARITY = 3'd3,
    ST_STOP   = 3'd4,
    ST_BREAK  = 3'd5
  } uart_state_e;

  // Parity modes
  localparam int PARITY_NONE = 0;
  localparam int PARITY_EVEN = 1;
  localparam int PARITY_ODD  = 2;

  // 100 MHz / 115200 baud
  localparam int DEFAULT_CLKS_PER_BIT = 868;

endpackage : uart_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Single-clock FIFO with a combinational head read. A push into
//               a full FIFO is accepted only when a pop happens in the same
//               cycle. The head reads as zero while empty.
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             i_push,
  input  logic [WIDTH-1:0] i_wdata,
  input  logic             i_pop,
  output logic [WIDTH-1:0] o_head,
  output logic             o_full,
  output logic             o_empty
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam logic [CW-1:0] CNT_FULL = CW'(DEPTH);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PW-1:0]    r_wr_ptr;
  logic [PW-1:0]    r_rd_ptr;
  logic [CW-1:0]    r_count;

  logic w_pop;
  logic w_push;

  assign o_empty = (r_count == '0);
  assign o_full  = (r_count == CNT_FULL);
  assign w_pop   = i_pop && !o_empty;
  assign w_push  = i_push && (!o_full || w_pop);
  assign o_head  = o_empty ? '0 : r_mem[r_rd_ptr];

  // Storage write; contents need no reset because the head is gated by empty
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wdata;
    end
  end

  // Pointer and occupancy tracking; pointers wrap naturally at DEPTH
  always_ff @(posedge clk) begin
    if (reset) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) r_wr_ptr <= r_wr_ptr + 1'b1;
      if (w_pop)  r_rd_ptr <= r_rd_ptr + 1'b1;
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_rx_capture.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_capture
// Description : UART receiver with two-flop input synchroniser, mid-bit
//               sampling, start-glitch rejection, stop/parity checking, break
//               handling and a small output FIFO behind valid/ready.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_capture
  import uart_pkg::*;
#(
  parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT,
  parameter int PARITY       = PARITY_NONE,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       rx,
  output logic [7:0] m_data,
  output logic       m_valid,
  input  logic       m_ready,
  output logic       frame_err,
  output logic       parity_err,
  output logic       overrun,
  input  logic       clr_overrun,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_BIT_LAST  = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] CNT_HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

  uart_state_e r_state;
  uart_state_e w_state_nxt;

  logic          r_sync1;
  logic          r_sync2;
  logic [CW-1:0] r_cnt;
  logic [2:0]    r_bit_idx;
  logic [7:0]    r_shift;
  logic          r_par_err;
  logic          r_frame_err;
  logic          r_parity_err;
  logic          r_overrun;

  logic w_rx_s;
  logic w_cnt_clr;
  logic w_frame_start;
  logic w_shift_en;
  logic w_par_en;
  logic w_par_bad;
  logic w_push;
  logic w_ferr;
  logic w_perr;
  logic w_pop;
  logic w_full;
  logic w_empty;
  logic w_drop;

  assign w_rx_s = r_sync2;

  // Parity check: XOR over data plus parity bit must be 0 (even) or 1 (odd)
  assign w_par_bad = (PARITY == PARITY_ODD) ? ~(^r_shift ^ w_rx_s)
                                            :  (^r_shift ^ w_rx_s);

  // Two-flop synchroniser for the asynchronous line, idling high
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= rx;
      r_sync2 <= r_sync1;
    end
  end

  // FSM state register
  always_ff @(posedge clk) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state decode and per-cycle strobes
  always_comb begin
    w_state_nxt   = r_state;
    w_cnt_clr     = 1'b0;
    w_frame_start = 1'b0;
    w_shift_en    = 1'b0;
    w_par_en      = 1'b0;
    w_push        = 1'b0;
    w_ferr        = 1'b0;
    w_perr        = 1'b0;
    case (r_state)
      ST_IDLE: begin
        if (!w_rx_s) begin
          w_state_nxt   = ST_START;
          w_cnt_clr     = 1'b1;
          w_frame_start = 1'b1;
        end
      end
      ST_START: begin
        if (r_cnt == CNT_HALF_LAST) begin
          w_cnt_clr   = 1'b1;
          w_state_nxt = w_rx_s ? ST_IDLE : ST_DATA;
        end
      end
      ST_DATA: begin
        if (r_cnt == CNT_BIT_LAST) begin
          w_cnt_clr  = 1'b1;
          w_shift_en = 1'b1;
          if (r_bit_idx == 3'd7) begin
            w_state_nxt = (PARITY != PARITY_NONE) ? ST_PARITY : ST_STOP;
          end
        end
      end
      ST_PARITY: begin
        if (r_cnt == CNT_BIT_LAST) begin
          w_cnt_clr   = 1'b1;
          w_par_en    = 1'b1;
          w_state_nxt = ST_STOP;
        end
      end
      ST_STOP: begin
        if (r_cnt == CNT_BIT_LAST) begin
          w_cnt_clr = 1'b1;
          if (!w_rx_s) begin
            w_ferr      = 1'b1;
            w_perr      = r_par_err;
            w_state_nxt = ST_BREAK;
          end else if (r_par_err) begin
            w_perr      = 1'b1;
            w_state_nxt = ST_IDLE;
          end else begin
            w_push      = 1'b1;
            w_state_nxt = ST_IDLE;
          end
        end
      end
      ST_BREAK: begin
        if (w_rx_s) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Bit timing counter, restarted at every sample point
  always_ff @(posedge clk) begin
    if (reset || w_cnt_clr) r_cnt <= '0;
    else                    r_cnt <= r_cnt + 1'b1;
  end

  // Data shift register (LSB first), bit index and latched parity result
  always_ff @(posedge clk) begin
    if (reset) begin
      r_shift   <= '0;
      r_bit_idx <= '0;
      r_par_err <= 1'b0;
    end else if (w_frame_start) begin
      r_bit_idx <= '0;
      r_par_err <= 1'b0;
    end else begin
      if (w_shift_en) begin
        r_shift   <= {w_rx_s, r_shift[7:1]};
        r_bit_idx <= r_bit_idx + 1'b1;
      end
      if (w_par_en) r_par_err <= w_par_bad;
    end
  end

  // Error pulses registered from the stop-sample cycle
  always_ff @(posedge clk) begin
    if (reset) begin
      r_frame_err  <= 1'b0;
      r_parity_err <= 1'b0;
    end else begin
      r_frame_err  <= w_ferr;
      r_parity_err <= w_perr;
    end
  end

  assign w_pop  = !w_empty && m_ready;
  assign w_drop = w_push && w_full && !w_pop;

  // Sticky overrun; a new drop outranks a simultaneous clear
  always_ff @(posedge clk) begin
    if (reset)            r_overrun <= 1'b0;
    else if (w_drop)      r_overrun <= 1'b1;
    else if (clr_overrun) r_overrun <= 1'b0;
  end

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .i_push  (w_push),
    .i_wdata (r_shift),
    .i_pop   (w_pop),
    .o_head  (m_data),
    .o_full  (w_full),
    .o_empty (w_empty)
  );

  assign m_valid    = !w_empty;
  assign frame_err  = r_frame_err;
  assign parity_err = r_parity_err;
  assign overrun    = r_overrun;
  assign busy       = (r_state != ST_IDLE);

endmodule : uart_rx_capture
`default_nettype wire

// File: tb/tb_uart_rx_capture.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_capture
// Description : Directed self-checking bench for uart_rx_capture. One
//               instance without parity, one with even parity.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_capture;

  localparam int CPB = 8;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       rx0 = 1'b1, rx1 = 1'b1;
  logic [7:0] m_data0, m_data1;
  logic       m_valid0, m_valid1;
  logic       m_ready0 = 1'b0, m_ready1 = 1'b0;
  logic       ferr0, ferr1, perr0, perr1;
  logic       ovr0, ovr1;
  logic       clr0 = 1'b0, clr1 = 1'b0;
  logic       busy0, busy1;

  int compared = 0;
  int failed   = 0;

  // Event counters sampled mid-cycle
  int n_ferr0 = 0, n_perr0 = 0, n_vcyc0 = 0, n_pop0 = 0;
  int n_perr1 = 0, n_vcyc1 = 0;
  logic [7:0] last0 = 8'h00;

  always #5 clk = ~clk;

  uart_rx_capture #(.CLKS_PER_BIT(CPB), .PARITY(0), .FIFO_DEPTH(4)) dut0 (
    .clk(clk), .reset(reset), .rx(rx0), .m_data(m_data0), .m_valid(m_valid0),
    .m_ready(m_ready0), .frame_err(ferr0), .parity_err(perr0),
    .overrun(ovr0), .clr_overrun(clr0), .busy(busy0));

  uart_rx_capture #(.CLKS_PER_BIT(CPB), .PARITY(1), .FIFO_DEPTH(4)) dut1 (
    .clk(clk), .reset(reset), .rx(rx1), .m_data(m_data1), .m_valid(m_valid1),
    .m_ready(m_ready1), .frame_err(ferr1), .parity_err(perr1),
    .overrun(ovr1), .clr_overrun(clr1), .busy(busy1));

  // Monitor of pulses, valid cycles and pops
  always @(negedge clk) begin
    if (!reset) begin
      if (ferr0) n_ferr0 <= n_ferr0 + 1;
      if (perr0) n_perr0 <= n_perr0 + 1;
      if (m_valid0) n_vcyc0 <= n_vcyc0 + 1;
      if (m_valid0 && m_ready0) begin
        n_pop0 <= n_pop0 + 1;
        last0  <= m_data0;
      end
      if (perr1) n_perr1 <= n_perr1 + 1;
      if (m_valid1) n_vcyc1 <= n_vcyc1 + 1;
    end
  end

  task automatic tick(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk(input string name, input int act, input int exp);
    compared++;
    if (act != exp) begin
      failed++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  task automatic drive(input bit sel, input logic v);
    if (sel) rx1 = v;
    else     rx0 = v;
  endtask

  // Serialise one frame: start, 8 data bits LSB first, optional parity, stop
  task automatic send_frame(input bit sel, input logic [7:0] d, input bit use_par,
                            input logic par, input logic stop);
    drive(sel, 1'b0);
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      drive(sel, d[i]);
      tick(CPB);
    end
    if (use_par) begin
      drive(sel, par);
      tick(CPB);
    end
    drive(sel, stop);
    tick(CPB);
  endtask

  // Pop one byte from dut0 with a single-cycle ready
  task automatic pop0(input string name, input logic [7:0] exp);
    chk({name, "_valid"}, int'(m_valid0), 1);
    chk({name, "_data"}, int'(m_data0), int'(exp));
    m_ready0 = 1'b1;
    tick();
    m_ready0 = 1'b0;
  endtask

  typedef struct {
    logic [7:0] data;
    logic       stop;
    int         exp_push;
    int         exp_ferr;
  } vec_t;

  vec_t vecs[5];

  initial begin
    int s_ferr, s_perr, s_vcyc, s_pop;

    vecs[0] = '{8'h55, 1'b1, 1, 0};
    vecs[1] = '{8'hA5, 1'b1, 1, 0};
    vecs[2] = '{8'h00, 1'b1, 1, 0};
    vecs[3] = '{8'hFF, 1'b1, 1, 0};
    vecs[4] = '{8'h3C, 1'b0, 0, 1};

    tick(3);
    reset = 1'b0;
    tick();
    chk("rst_valid", int'(m_valid0), 0);
    chk("rst_data", int'(m_data0), 0);
    chk("rst_busy", int'(busy0), 0);
    chk("rst_overrun", int'(ovr0), 0);
    chk("rst_errs", int'({ferr0, perr0}), 0);

    // Single frames with consumer always ready
    m_ready0 = 1'b1;
    for (int v = 0; v < 5; v++) begin
      s_ferr = n_ferr0; s_perr = n_perr0; s_vcyc = n_vcyc0; s_pop = n_pop0;
      send_frame(1'b0, vecs[v].data, 1'b0, 1'b0, vecs[v].stop);
      drive(1'b0, 1'b1);
      tick(3 * CPB);
      chk($sformatf("v%0d_valid_cycles", v), n_vcyc0 - s_vcyc, vecs[v].exp_push);
      chk($sformatf("v%0d_pops", v), n_pop0 - s_pop, vecs[v].exp_push);
      chk($sformatf("v%0d_frame_err", v), n_ferr0 - s_ferr, vecs[v].exp_ferr);
      chk($sformatf("v%0d_parity_err", v), n_perr0 - s_perr, 0);
      chk($sformatf("v%0d_busy", v), int'(busy0), 0);
      if (vecs[v].exp_push == 1) chk($sformatf("v%0d_data", v), int'(last0), int'(vecs[v].data));
    end
    m_ready0 = 1'b0;

    // Start glitch of 3 cycles is rejected
    s_ferr = n_ferr0; s_vcyc = n_vcyc0;
    rx0 = 1'b0;
    tick(3);
    rx0 = 1'b1;
    tick(2 * CPB);
    chk("glitch_valid", n_vcyc0 - s_vcyc, 0);
    chk("glitch_ferr", n_ferr0 - s_ferr, 0);
    chk("glitch_busy", int'(busy0), 0);

    // Frame error followed by a held-low break
    s_ferr = n_ferr0; s_vcyc = n_vcyc0;
    send_frame(1'b0, 8'h81, 1'b0, 1'b0, 1'b0);
    tick(40 - CPB);
    chk("break_busy", int'(busy0), 1);
    chk("break_ferr", n_ferr0 - s_ferr, 1);
    chk("break_nopush", n_vcyc0 - s_vcyc, 0);
    rx0 = 1'b1;
    tick(5);
    chk("break_release_busy", int'(busy0), 0);
    chk("break_ferr_once", n_ferr0 - s_ferr, 1);

    // Back-to-back frames held in the FIFO
    send_frame(1'b0, 8'hA5, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    send_frame(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
    tick(CPB);
    pop0("b2b0", 8'hA5);
    pop0("b2b1", 8'h3C);
    pop0("b2b2", 8'h00);
    chk("b2b_empty", int'(m_valid0), 0);

    // Overrun: five frames into a four-entry FIFO
    for (int i = 1; i <= 5; i++) send_frame(1'b0, 8'(i), 1'b0, 1'b0, 1'b1);
    tick(CPB);
    chk("ovr_set", int'(ovr0), 1);
    for (int i = 1; i <= 4; i++) pop0($sformatf("ovr_pop%0d", i), 8'(i));
    chk("ovr_empty", int'(m_valid0), 0);
    chk("ovr_sticky", int'(ovr0), 1);
    clr0 = 1'b1;
    tick();
    clr0 = 1'b0;
    chk("ovr_clear", int'(ovr0), 0);

    // Even parity: 0x07 has three ones, so the correct parity bit is 1
    s_vcyc = n_vcyc1;
    send_frame(1'b1, 8'h07, 1'b1, 1'b0, 1'b1);
    tick(2 * CPB);
    chk("par_bad_perr", n_perr1, 1);
    chk("par_bad_nopush", n_vcyc1 - s_vcyc, 0);
    send_frame(1'b1, 8'h07, 1'b1, 1'b1, 1'b1);
    tick(2 * CPB);
    chk("par_ok_valid", int'(m_valid1), 1);
    chk("par_ok_data", int'(m_data1), 8'h07);
    chk("par_ok_perr", n_perr1, 1);

    // Reset in the middle of data bit 4, with one byte already buffered
    send_frame(1'b0, 8'h99, 1'b0, 1'b0, 1'b1);
    tick(CPB);
    chk("mid_pre_valid", int'(m_valid0), 1);
    rx0 = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx0 = 1'(i & 1);
      tick(CPB);
    end
    rx0 = 1'b1;
    tick(CPB / 2);
    chk("mid_pre_busy", int'(busy0), 1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk("mid_busy", int'(busy0), 0);
    chk("mid_valid", int'(m_valid0), 0);
    chk("mid_data", int'(m_data0), 0);
    tick(2 * CPB);
    send_frame(1'b0, 8'h3C, 1'b0, 1'b0, 1'b1);
    tick(CPB);
    pop0("mid_after", 8'h3C);
    chk("mid_after_empty", int'(m_valid0), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, failed);
    $finish;
  end

endmodule : tb_uart_rx_capture
`default_nettype wire

// File: doc/uart_rx_capture.md
Name: uart_rx_capture

Overview:
UART receiver that deserialises the SoC's `tx0` line into bytes. It gives the AISoC bench and host-side logic a checked, buffered view of everything the SoC transmits. It sits on the far end of the SoC UART link, opposite the SoC's own transmitter. The line is sampled at mid-bit with start-glitch rejection, and frames are checked for stop/parity errors. Accepted bytes are buffered in a small FIFO behind a valid/ready output.

Parameters:
- CLKS_PER_BIT, 868, clk cycles per UART bit (100 MHz / 115200); must be >= 4.
- PARITY, 0, 0 = none, 1 = even, 2 = odd.
- FIFO_DEPTH, 4, number of byte entries; power of 2, >= 2.

Ports:
- clk  in  1  system clock (single clock domain)
- reset  in  1  synchronous, active-high reset
- rx  in  1  serial line (connects to SoC `tx0`); asynchronous, idle high
- m_data  out  8  byte at FIFO head
- m_valid  out  1  FIFO non-empty
- m_ready  in  1  consumer accepts `m_data` this cycle when `m_valid`=1
- frame_err  out  1  one-cycle pulse: stop bit sampled 0
- parity_err  out  1  one-cycle pulse: parity mismatch
- overrun  out  1  sticky: a good byte was dropped because the FIFO was full
- clr_overrun  in  1  clears `overrun`
- busy  out  1  FSM not in IDLE

Behaviour:
- Clock and reset: one clock `clk`; `reset` is synchronous and active-high. Assertion at any time, including mid-frame, forces the following on the next edge:
  - FSM to IDLE, FIFO empty.
  - All outputs to 0, including `m_data`=0x00.
  - Synchroniser flops to 1.
- Synchroniser: `rx` passes through 2 flops (`rx_s`) before any use; all timing below is relative to `rx_s`.
- FSM: IDLE -> START -> DATA -> [PARITY] -> STOP -> IDLE; plus BREAK.
  - IDLE: `rx_s`=0 -> START; bit counter cleared to 0.
  - START: wait CLKS_PER_BIT/2 (floor) cycles, then sample.
    - Sample 1: glitch; return to IDLE with no output.
    - Sample 0: go to DATA.
  - DATA: every CLKS_PER_BIT cycles, sample one bit; bits arrive LSB first into an 8-bit shift register.
    - After 8 bits: go to PARITY if PARITY != 0, else STOP.
  - PARITY: sample after CLKS_PER_BIT cycles.
    - Error if the XOR of the 8 data bits and the parity bit is not 0 (even) or not 1 (odd).
  - STOP: sample after CLKS_PER_BIT cycles.
    - Sample 1 and no parity error: push the byte; next state IDLE.
    - Sample 0: pulse `frame_err`, discard the byte; go to BREAK.
    - Parity error with good stop: pulse `parity_err`, discard the byte; go to IDLE.
    - Both errors together: pulse both flags; go to BREAK.
  - BREAK: stay until `rx_s`=1, then IDLE. A held-low line produces no further frames.
- Push timing: the push happens on the stop-sample cycle. `m_valid` rises on the following edge, so latency from stop-sample to `m_valid` is 1 cycle.
- FIFO push/pop rules:
  - Pop occurs when `m_valid` & `m_ready`.
  - Push is accepted if the FIFO is not full, or if a pop happens in the same cycle (full + pop + push keeps the count at FIFO_DEPTH).
  - Push while full with no pop: byte dropped, `overrun` set to 1.
  - Pointers wrap modulo FIFO_DEPTH; count width is clog2(FIFO_DEPTH)+1.
  - `m_data` is the combinational read of the head entry; it is 0x00 when empty.
- Overrun: `clr_overrun` in the same cycle as a new overrun event leaves `overrun`=1 (set wins).
- Error pulses are exactly 1 cycle wide and never coincide with a push.
- `busy`=1 in START, DATA, PARITY, STOP and BREAK.

Decomposition:
- Shared package `uart_pkg`:
  - FSM state encoding (IDLE, START, DATA, PARITY, STOP, BREAK).
  - PARITY_NONE/EVEN/ODD constants.
  - Default CLKS_PER_BIT.
- One sub-module: `sync_fifo`, parameters WIDTH=8 and DEPTH=FIFO_DEPTH. Interface: push/pop/full/empty/head. It is reused later for a matching transmitter.

Test Plan:
All scenarios use CLKS_PER_BIT=8; FIFO_DEPTH=4 unless stated.
1. Drive frame 0x55 (PARITY=0), `m_ready`=1 -> `m_valid` for exactly 1 cycle, `m_data`=0x55; no error pulses; `busy` low after stop.
2. Back-to-back frames 0xA5, 0x3C, 0x00 with `m_ready`=0 -> `m_valid`=1, then pops return 0xA5, 0x3C, 0x00 in order; FIFO ends empty.
3. Low glitch on `rx` for 3 cycles -> START aborts to IDLE; `m_valid`, `frame_err` and `parity_err` stay 0.
4. Frame 0x81 with stop bit 0 held low for 40 cycles -> one `frame_err` pulse, no push, `busy`=1 until `rx` returns high.
5. Five frames 0x01..0x05 with `m_ready`=0 -> 4 stored, `overrun`=1, then pops return 0x01..0x04. Pulse `clr_overrun` -> `overrun`=0.
6. PARITY=1, frame 0x07 with parity bit 0 -> one `parity_err` pulse, no push. Same frame with parity bit 1 -> `m_data`=0x07.
7. Assert `reset` during DATA bit 4 -> next cycle `busy`=0 and FIFO empty. A subsequent frame 0x3C is received correctly.
